scv_keymatrix: RTL and testbench

- Consumes the merged hmi_t from the joystick/keyboard merge stage and presents it to the CPU as the SCV key matrix.
- The CPU drives active-low column strobes on port A and reads active-low row data on port B.
- Each key press is stretched, so a press shorter than one CPU scan period is still seen by at least one full scan.
- Pause is taken out of the matrix as a stretched level for the interrupt logic.

---
 rtl/scv_pkg.sv | 66 ++++++
 rtl/key_stretch.sv | 38 +++
 rtl/scv_keymatrix.sv | 87 ++++++++
 tb/tb_scv_keymatrix.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/scv_pkg.sv
// Shared SCV types: the merged controller/keypad state and the key-matrix map
// used to present that state to the CPU.
package scv_pkg;

    typedef struct packed {
        logic t2;
        logic t1;
        logic u;
        logic d;
        logic l;
        logic r;
    } pad_t;

    typedef struct packed {
        pad_t       c1;
        pad_t       c2;
        logic [9:0] num;
        logic       cl;
        logic       en;
        logic       pause;
    } hmi_t;

    localparam int unsigned NUM_KEYS = $bits(hmi_t);

    // Key indices are the bit positions of each field inside a packed hmi_t
    localparam logic [4:0] KEY_PAUSE = 5'd0;
    localparam logic [4:0] KEY_EN    = 5'd1;
    localparam logic [4:0] KEY_CL    = 5'd2;
    localparam logic [4:0] KEY_NUM0  = 5'd3;
    localparam logic [4:0] KEY_NUM8  = 5'd11;
    localparam logic [4:0] KEY_NUM9  = 5'd12;
    localparam logic [4:0] KEY_C2_R  = 5'd13;
    localparam logic [4:0] KEY_C1_R  = 5'd19;

    localparam int unsigned MTX_COLS = 8;
    localparam int unsigned MTX_ROWS = 8;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_ARMED,
        KS_AGED
    } keyfsm_t;

    // Returns {valid, key index} for a column/row position; valid=0 means released
    function automatic logic [5:0] key_at(input logic [2:0] col, input logic [2:0] row);
        logic [5:0] m;
        m = '0;
        case (col)
            3'd0: if (row < 3'd6) m = {1'b1, KEY_C1_R + {2'b00, row}};
            3'd1: if (row < 3'd6) m = {1'b1, KEY_C2_R + {2'b00, row}};
            3'd2: m = {1'b1, KEY_NUM0 + {2'b00, row}};
            3'd3: begin
                case (row)
                    3'd0: m = {1'b1, KEY_NUM8};
                    3'd1: m = {1'b1, KEY_NUM9};
                    3'd2: m = {1'b1, KEY_CL};
                    3'd3: m = {1'b1, KEY_EN};
                    default: m = '0;
                endcase
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/key_stretch.sv
// Per-key press stretcher: a rising edge arms the key, and it is released
// only after two further ticks of the shared timer.
module key_stretch
    import scv_pkg::*;
(
    input  logic CLK_SYS,
    input  logic RESB,
    input  logic rise,
    input  logic tick,
    output logic active
);

    keyfsm_t state, state_nxt;

    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB) state <= KS_IDLE;
        else       state <= state_nxt;
    end

    // A new press always restarts the window, even on a tick cycle
    always_comb begin
        state_nxt = state;
        if (rise) begin
            state_nxt = KS_ARMED;
        end else if (tick) begin
            case (state)
                KS_ARMED: state_nxt = KS_AGED;
                KS_AGED:  state_nxt = KS_IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        active = (state != KS_IDLE);
    end

endmodule

// File: rtl/scv_keymatrix.sv
// SCV key matrix: stretches HMI key presses and serves them to the CPU as
// active-low rows selected by active-low column strobes; pause is split out.
module scv_keymatrix
    import scv_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 200000,
    parameter int unsigned HOLD_W      = 18
) (
    input  logic       CLK_SYS,
    input  logic       RESB,
    input  hmi_t       HMI,
    input  logic [7:0] PA_O,
    output logic [7:0] PB_I,
    output logic       PAUSE
);

    hmi_t                raw_p0;
    hmi_t                raw_p1;
    logic [NUM_KEYS-1:0] raw_v;
    logic [NUM_KEYS-1:0] raw_d_v;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] active;
    logic [NUM_KEYS-1:0] eff;
    logic [HOLD_W-1:0]   tick_cnt;
    logic                tick;
    logic [7:0]          row_hit;

    // Stage p0: HMI capture, p1: previous sample for edge detection
    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB) begin
            raw_p0 <= '0;
            raw_p1 <= '0;
        end else begin
            raw_p0 <= HMI;
            raw_p1 <= raw_p0;
        end
    end

    assign raw_v   = raw_p0;
    assign raw_d_v = raw_p1;
    assign rise    = raw_v & ~raw_d_v;

    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + HOLD_W'(1);
    end

    assign tick = (tick_cnt == HOLD_W'(HOLD_CYCLES - 1));

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_stretch u_key (
            .CLK_SYS (CLK_SYS),
            .RESB    (RESB),
            .rise    (rise[k]),
            .tick    (tick),
            .active  (active[k])
        );
    end

    assign eff = raw_v | active;

    // Any strobed column pulls a row low when its mapped key is asserted
    always_comb begin
        logic [5:0] m;
        row_hit = '0;
        m       = '0;
        for (int c = 0; c < MTX_COLS; c++) begin
            for (int n = 0; n < MTX_ROWS; n++) begin
                m = key_at(3'(c), 3'(n));
                if (m[5] && !PA_O[c]) row_hit[n] = row_hit[n] | eff[m[4:0]];
            end
        end
    end

    // Stage p2: registered CPU row data and pause level
    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB) begin
            PB_I  <= 8'hFF;
            PAUSE <= 1'b0;
        end else begin
            PB_I  <= ~row_hit;
            PAUSE <= eff[KEY_PAUSE];
        end
    end

endmodule

// File: tb/tb_scv_keymatrix.sv
// Directed bench for scv_keymatrix with a per-cycle scoreboard built from an
// independent deadline model of the key stretch.
module tb_scv_keymatrix;
    import scv_pkg::*;

    localparam int HOLD = 16;

    logic       CLK_SYS = 1'b0;
    logic       RESB    = 1'b0;
    hmi_t       HMI;
    logic [7:0] PA_O;
    logic [7:0] PB_I;
    logic       PAUSE;

    scv_keymatrix #(.HOLD_CYCLES(HOLD), .HOLD_W(5)) dut (
        .CLK_SYS (CLK_SYS),
        .RESB    (RESB),
        .HMI     (HMI),
        .PA_O    (PA_O),
        .PB_I    (PB_I),
        .PAUSE   (PAUSE)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    int         n_cmp = 0;
    int         n_bad = 0;
    hmi_t       m_raw;
    hmi_t       m_raw_d;
    int         pend [25];
    int         m_cnt;
    logic [8:0] exp_q [$];
    int         dur;
    int         first;
    int         idx;

    function automatic logic [7:0] model_pb(input hmi_t e, input logic [7:0] pa);
        logic [7:0] hit;
        hit = 8'h00;
        if (!pa[0]) hit = hit | {2'b00, e.c1};
        if (!pa[1]) hit = hit | {2'b00, e.c2};
        if (!pa[2]) hit = hit | e.num[7:0];
        if (!pa[3]) hit = hit | {4'b0000, e.en, e.cl, e.num[9], e.num[8]};
        return ~hit;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int val, input int lo, input int hi);
        n_cmp++;
        assert (val >= lo && val <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_raw   = '0;
        m_raw_d = '0;
        m_cnt   = 0;
        for (int k = 0; k < 25; k++) pend[k] = 0;
        exp_q.delete();
    endtask

    // Keys stay stretched until two timer ticks have passed since the last press
    task automatic step();
        logic [24:0] rv;
        logic [24:0] rdv;
        logic [24:0] ev;
        logic        tk;
        logic [8:0]  e;
        hmi_t        ef;
        rv  = m_raw;
        rdv = m_raw_d;
        tk  = (m_cnt == HOLD - 1);
        for (int k = 0; k < 25; k++) ev[k] = rv[k] | (pend[k] != 0);
        ef = hmi_t'(ev);
        exp_q.push_back({model_pb(ef, PA_O), ef.pause});
        @(posedge CLK_SYS);
        for (int k = 0; k < 25; k++) begin
            if (rv[k] && !rdv[k])      pend[k] = 2;
            else if (tk && pend[k] > 0) pend[k] = pend[k] - 1;
        end
        m_raw_d = m_raw;
        m_raw   = HMI;
        m_cnt   = tk ? 0 : m_cnt + 1;
        #1;
        e = exp_q.pop_front();
        check("pb_i", PB_I, e[8:1]);
        check("pause", {7'b0, PAUSE}, {7'b0, e[0]});
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 2 * HOLD && m_cnt != target; i++) step();
    endtask

    initial begin
        HMI  = '0;
        PA_O = 8'hFF;
        model_reset();
        repeat (3) @(posedge CLK_SYS);
        #1;
        check("rst_pb_i", PB_I, 8'hFF);
        check("rst_pause", {7'b0, PAUSE}, 8'h00);
        RESB = 1'b1;

        PA_O = 8'hFE;
        repeat (2) step();
        check("idle_pb_i", PB_I, 8'hFF);
        check("idle_pause", {7'b0, PAUSE}, 8'h00);

        HMI.c1.u = 1'b1;
        repeat (2) step();
        check("c1u_col0", PB_I, 8'hF7);
        PA_O = 8'hFD;
        step();
        check("c1u_col1", PB_I, 8'hFF);
        HMI  = '0;
        PA_O = 8'hFF;
        repeat (40) step();

        // Single-cycle tap away from a tick
        PA_O = 8'hFB;
        wait_cnt(3);
        HMI.num[3] = 1'b1;
        step();
        HMI   = '0;
        idx   = 1;
        dur   = 0;
        first = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            idx++;
            if (PB_I[3] == 1'b0) begin
                dur++;
                if (first < 0) first = idx;
            end
        end
        check_rng("tap_first_low", first, 2, 2);
        check_rng("tap_dur", dur, 17, 32);
        check("tap_release", PB_I, 8'hFF);

        HMI.en     = 1'b1;
        HMI.num[0] = 1'b1;
        PA_O       = 8'hF3;
        repeat (2) step();
        check("two_cols", PB_I, 8'hF6);
        HMI = '0;
        repeat (40) step();

        // Press whose rising edge lands on the tick cycle
        PA_O = 8'hFB;
        wait_cnt(HOLD - 2);
        HMI.num[3] = 1'b1;
        step();
        HMI = '0;
        dur = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (PB_I[3] == 1'b0) dur++;
        end
        check_rng("tick_rise_dur", dur, 33, 33);

        PA_O = 8'hFF;
        wait_cnt(3);
        HMI.pause = 1'b1;
        step();
        HMI = '0;
        check("pause_lat1", {7'b0, PAUSE}, 8'h00);
        step();
        check("pause_lat2", {7'b0, PAUSE}, 8'h01);
        for (int i = 0; i < 3 * HOLD && pend[0] != 1; i++) step();
        repeat (2) step();
        HMI.pause = 1'b1;
        step();
        HMI = '0;
        dur = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (PAUSE) dur++;
        end
        check_rng("pause_retap_dur", dur, 17, 32);

        // Asynchronous reset with stretched keys outstanding
        PA_O       = 8'hFB;
        HMI.num[3] = 1'b1;
        HMI.pause  = 1'b1;
        repeat (3) step();
        HMI = '0;
        #2;
        RESB = 1'b0;
        #1;
        check("async_pb_i", PB_I, 8'hFF);
        check("async_pause", {7'b0, PAUSE}, 8'h00);
        repeat (2) @(posedge CLK_SYS);
        #3;
        RESB = 1'b1;
        model_reset();
        dur = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (PB_I != 8'hFF || PAUSE) dur++;
        end
        check_rng("no_stale", dur, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: observed no end expected end of test");
        $fatal(1, "timeout");
    end

endmodule
